// File: rtl/ram_port_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : ram_port_ctrl
//  Brief    : Initiator-side controller for a synchronous single-write /
//             registered-read RAM. Turns single read/write requests into
//             correctly timed RAM port cycles and provides an auto-scan mode
//             that streams every RAM word out in address order.
//  Options  : `define SCAN_CHECKSUM_EN adds the scan_sum output (running
//             modulo-2**DW sum of the scan beats of the current scan).
//  Revision : 1.0  - initial release
// ============================================================================
module ram_port_ctrl #(
  parameter int AW = 4,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          clrn,
  // user request side
  input  logic          req,
  input  logic          cmd_wr,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] wdata,
  output logic          ready,
  output logic [DW-1:0] rdata,
  output logic          rvalid,
  output logic          wdone,
  // auto-scan side
  input  logic          scan_start,
  output logic          scan_busy,
  output logic [AW-1:0] scan_addr,
  output logic [DW-1:0] scan_data,
  output logic          scan_valid,
  // RAM port side
  output logic          ram_we,
  output logic [AW-1:0] ram_inaddr,
  output logic [DW-1:0] ram_indata,
  output logic [AW-1:0] ram_outaddr,
`ifdef SCAN_CHECKSUM_EN
  input  logic [DW-1:0] ram_outdata,
  output logic [DW-1:0] scan_sum
`else
  input  logic [DW-1:0] ram_outdata
`endif
);

  // --------------------------------------------------------------------------
  // State encoding
  // --------------------------------------------------------------------------
  localparam int SW = 3;
  localparam logic [SW-1:0] S_IDLE       = 3'd0;
  localparam logic [SW-1:0] S_WR         = 3'd1;
  localparam logic [SW-1:0] S_RD_ISS     = 3'd2;
  localparam logic [SW-1:0] S_RD_CAP     = 3'd3;
  localparam logic [SW-1:0] S_SCAN       = 3'd4;
  localparam logic [SW-1:0] S_SCAN_DRAIN = 3'd5;

  // Last address of the RAM; the scan pointer stops here instead of wrapping.
  localparam logic [AW-1:0] PTR_LAST = {AW{1'b1}};
  localparam logic [AW-1:0] PTR_ONE  = {{(AW-1){1'b0}}, 1'b1};
  localparam logic [AW-1:0] PTR_ZERO = {AW{1'b0}};

  logic [SW-1:0] state;
  logic [SW-1:0] state_nxt;

  // Request / scan acceptance decodes, only meaningful in IDLE.
  logic          accept_wr;
  logic          accept_rd;
  logic          scan_accept;

  // Scan pipeline stage: the address issued to the RAM in the previous cycle,
  // whose data is now on ram_outdata.
  logic          pipe_valid;
  logic [AW-1:0] pipe_addr;
  logic          pipe_valid_nxt;
  logic [AW-1:0] pipe_addr_nxt;

  // Next values of the registered outputs.
  logic          ready_nxt;
  logic          rvalid_nxt;
  logic          wdone_nxt;
  logic [DW-1:0] rdata_nxt;
  logic          scan_busy_nxt;
  logic          scan_valid_nxt;
  logic [AW-1:0] scan_addr_nxt;
  logic [DW-1:0] scan_data_nxt;
  logic          ram_we_nxt;
  logic [AW-1:0] ram_inaddr_nxt;
  logic [DW-1:0] ram_indata_nxt;
  logic [AW-1:0] ram_outaddr_nxt;

  // --------------------------------------------------------------------------
  // Acceptance decode: a request beats a simultaneous scan_start, and
  // scan_start is only looked at when no request is present.
  // --------------------------------------------------------------------------
  assign accept_wr   = (state == S_IDLE) &&  req &&  cmd_wr;
  assign accept_rd   = (state == S_IDLE) &&  req && !cmd_wr;
  assign scan_accept = (state == S_IDLE) && !req &&  scan_start;

  // State register; a low clrn returns to IDLE and abandons any activity.
  always_ff @(posedge clk) begin
    if (!clrn) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic for the request and scan sequences.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (req) begin
          state_nxt = cmd_wr ? S_WR : S_RD_ISS;
        end else if (scan_start) begin
          state_nxt = S_SCAN;
        end
      end
      S_WR:     state_nxt = S_IDLE;
      S_RD_ISS: state_nxt = S_RD_CAP;
      S_RD_CAP: state_nxt = S_IDLE;
      S_SCAN: begin
        // The last address is on the RAM port this cycle; only the
        // pipelined beats remain after it.
        if (ram_outaddr == PTR_LAST) begin
          state_nxt = S_SCAN_DRAIN;
        end
      end
      S_SCAN_DRAIN: begin
        // Once the pipeline stage is empty the beat being presented now is
        // the final one, so the scan is over at the next edge.
        if (!pipe_valid) begin
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Output logic: next values for every registered output and pipe stage.
  always_comb begin
    // Status strobes follow the state being entered / left.
    ready_nxt     = (state_nxt == S_IDLE);
    ram_we_nxt    = (state_nxt == S_WR);
    wdone_nxt     = (state == S_WR);
    rvalid_nxt    = (state == S_RD_CAP);
    scan_busy_nxt = (state_nxt == S_SCAN) || (state_nxt == S_SCAN_DRAIN);

    // Write port holds its last address/data except when a write is taken.
    ram_inaddr_nxt = ram_inaddr;
    ram_indata_nxt = ram_indata;
    if (accept_wr) begin
      ram_inaddr_nxt = addr;
      ram_indata_nxt = wdata;
    end

    // Read address: request address on a read, pointer during a scan.
    ram_outaddr_nxt = ram_outaddr;
    if (accept_rd) begin
      ram_outaddr_nxt = addr;
    end else if (scan_accept) begin
      ram_outaddr_nxt = PTR_ZERO;
    end else if ((state == S_SCAN) && (ram_outaddr != PTR_LAST)) begin
      ram_outaddr_nxt = ram_outaddr + PTR_ONE;
    end

    // Read result is captured from the RAM during RD_CAP and held otherwise.
    rdata_nxt = rdata;
    if (state == S_RD_CAP) begin
      rdata_nxt = ram_outdata;
    end

    // Scan pipe: an address driven in SCAN has its data one cycle later.
    pipe_valid_nxt = (state == S_SCAN);
    pipe_addr_nxt  = ram_outaddr;

    // Scan beat: presented the cycle after the pipe stage, i.e. two cycles
    // after its address was driven.
    scan_valid_nxt = pipe_valid;
    scan_addr_nxt  = scan_addr;
    scan_data_nxt  = scan_data;
    if (pipe_valid) begin
      scan_addr_nxt = pipe_addr;
      scan_data_nxt = ram_outdata;
    end
  end

  // Output and pipeline registers; reset clears all but ready.
  always_ff @(posedge clk) begin
    if (!clrn) begin
      ready       <= 1'b1;
      rdata       <= '0;
      rvalid      <= 1'b0;
      wdone       <= 1'b0;
      scan_busy   <= 1'b0;
      scan_valid  <= 1'b0;
      scan_addr   <= '0;
      scan_data   <= '0;
      ram_we      <= 1'b0;
      ram_inaddr  <= '0;
      ram_indata  <= '0;
      ram_outaddr <= '0;
      pipe_valid  <= 1'b0;
      pipe_addr   <= '0;
    end else begin
      ready       <= ready_nxt;
      rdata       <= rdata_nxt;
      rvalid      <= rvalid_nxt;
      wdone       <= wdone_nxt;
      scan_busy   <= scan_busy_nxt;
      scan_valid  <= scan_valid_nxt;
      scan_addr   <= scan_addr_nxt;
      scan_data   <= scan_data_nxt;
      ram_we      <= ram_we_nxt;
      ram_inaddr  <= ram_inaddr_nxt;
      ram_indata  <= ram_indata_nxt;
      ram_outaddr <= ram_outaddr_nxt;
      pipe_valid  <= pipe_valid_nxt;
      pipe_addr   <= pipe_addr_nxt;
    end
  end

`ifdef SCAN_CHECKSUM_EN
  // Running scan checksum: cleared when a scan is accepted, summed per beat.
  always_ff @(posedge clk) begin
    if (!clrn) begin
      scan_sum <= '0;
    end else if (scan_accept) begin
      scan_sum <= '0;
    end else if (scan_valid) begin
      scan_sum <= scan_sum + scan_data;
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_ram_port_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ram_port_ctrl
//  Brief    : Self-checking bench for ram_port_ctrl with a 16x8 synchronous
//             RAM model (write port, registered read port when we=0).
//  Revision : 1.0  - initial release
// ============================================================================
module tb_ram_port_ctrl;

  localparam int AW = 4;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          clrn;
  logic          req;
  logic          cmd_wr;
  logic [AW-1:0] addr;
  logic [DW-1:0] wdata;
  logic          ready;
  logic [DW-1:0] rdata;
  logic          rvalid;
  logic          wdone;
  logic          scan_start;
  logic          scan_busy;
  logic [AW-1:0] scan_addr;
  logic [DW-1:0] scan_data;
  logic          scan_valid;
  logic          ram_we;
  logic [AW-1:0] ram_inaddr;
  logic [DW-1:0] ram_indata;
  logic [AW-1:0] ram_outaddr;
  logic [DW-1:0] ram_outdata;
`ifdef SCAN_CHECKSUM_EN
  logic [DW-1:0] scan_sum;
`endif

  int checks   = 0;
  int failures = 0;

  ram_port_ctrl #(.AW(AW), .DW(DW)) dut (
    .clk         (clk),
    .clrn        (clrn),
    .req         (req),
    .cmd_wr      (cmd_wr),
    .addr        (addr),
    .wdata       (wdata),
    .ready       (ready),
    .rdata       (rdata),
    .rvalid      (rvalid),
    .wdone       (wdone),
    .scan_start  (scan_start),
    .scan_busy   (scan_busy),
    .scan_addr   (scan_addr),
    .scan_data   (scan_data),
    .scan_valid  (scan_valid),
    .ram_we      (ram_we),
    .ram_inaddr  (ram_inaddr),
    .ram_indata  (ram_indata),
    .ram_outaddr (ram_outaddr),
`ifdef SCAN_CHECKSUM_EN
    .ram_outdata (ram_outdata),
    .scan_sum    (scan_sum)
`else
    .ram_outdata (ram_outdata)
`endif
  );

  always #5 clk = ~clk;

  // 16x8 synchronous RAM: write when we=1, otherwise register the read word.
  logic [DW-1:0] mem [16];
  always @(posedge clk) begin
    if (ram_we) mem[ram_inaddr] <= ram_indata;
    else        ram_outdata     <= mem[ram_outaddr];
  end

  // Request table: write/read transactions with hand-computed read results.
  typedef struct {
    bit            is_wr;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    logic [DW-1:0] exp_rdata;
  } vec_t;

  vec_t vecs [7];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_b(input string nm, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %b expected %b (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic chk_v(input string nm, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!ready && n < 50) begin
      tick();
      n++;
    end
    chk_b("ready_wait", ready, 1'b1);
  endtask

  task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
    wait_ready();
    req = 1'b1; cmd_wr = 1'b1; addr = a; wdata = d;
    tick();
    req = 1'b0; cmd_wr = 1'b0; addr = '0; wdata = '0;
    chk_b("wr_we_on", ram_we, 1'b1);
    chk_v("wr_inaddr", {4'h0, ram_inaddr}, {4'h0, a});
    chk_v("wr_indata", ram_indata, d);
    chk_b("wr_ready_low", ready, 1'b0);
    chk_b("wr_wdone_early", wdone, 1'b0);
    tick();
    chk_b("wr_we_off", ram_we, 1'b0);
    chk_b("wr_wdone", wdone, 1'b1);
    chk_b("wr_ready_back", ready, 1'b1);
  endtask

  task automatic do_read(input logic [AW-1:0] a, input logic [DW-1:0] exp);
    wait_ready();
    req = 1'b1; cmd_wr = 1'b0; addr = a; wdata = 8'hEE;
    tick();
    req = 1'b0; addr = '0; wdata = '0;
    chk_b("rd_ready_low", ready, 1'b0);
    chk_b("rd_we_iss", ram_we, 1'b0);
    chk_v("rd_outaddr", {4'h0, ram_outaddr}, {4'h0, a});
    chk_b("rd_rvalid_e0", rvalid, 1'b0);
    tick();
    chk_b("rd_we_cap", ram_we, 1'b0);
    chk_b("rd_rvalid_e1", rvalid, 1'b0);
    tick();
    chk_b("rd_rvalid", rvalid, 1'b1);
    chk_v("rd_rdata", rdata, exp);
    chk_b("rd_ready_e2", ready, 1'b1);
    tick();
    chk_b("rd_rvalid_pulse", rvalid, 1'b0);
    chk_v("rd_rdata_hold", rdata, exp);
  endtask

  // Safety net so the bench always terminates.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int beats;
    int n;

    vecs[0] = '{1'b1, 4'd3,  8'hA5, 8'h00};
    vecs[1] = '{1'b0, 4'd3,  8'h00, 8'hA5};
    vecs[2] = '{1'b1, 4'd15, 8'h3C, 8'h00};
    vecs[3] = '{1'b0, 4'd15, 8'h00, 8'h3C};
    vecs[4] = '{1'b1, 4'd0,  8'h5A, 8'h00};
    vecs[5] = '{1'b0, 4'd0,  8'h00, 8'h5A};
    vecs[6] = '{1'b0, 4'd3,  8'h00, 8'hA5};

    clrn = 1'b0; req = 1'b0; cmd_wr = 1'b0; addr = '0; wdata = '0;
    scan_start = 1'b0;

    // Reset state
    repeat (2) tick();
    chk_b("rst_ready", ready, 1'b1);
    chk_b("rst_we", ram_we, 1'b0);
    chk_b("rst_rvalid", rvalid, 1'b0);
    chk_b("rst_wdone", wdone, 1'b0);
    chk_b("rst_scan_valid", scan_valid, 1'b0);
    chk_b("rst_scan_busy", scan_busy, 1'b0);
    chk_v("rst_rdata", rdata, 8'h00);
    clrn = 1'b1;
    tick();

    // Table-driven write/read traffic (reads issued on the first ready cycle)
    for (int i = 0; i < 7; i++) begin
      if (vecs[i].is_wr) do_write(vecs[i].a, vecs[i].d);
      else               do_read(vecs[i].a, vecs[i].exp_rdata);
    end

    // Full scan of i*0x11 pattern, with a write request held (must be ignored)
    for (int i = 0; i < 16; i++) do_write(4'(i), 8'(i * 17));
    wait_ready();
    scan_start = 1'b1;
    tick();
    scan_start = 1'b0;
    chk_b("scan_busy_start", scan_busy, 1'b1);
    chk_b("scan_ready_low", ready, 1'b0);
    chk_b("scan_valid_early", scan_valid, 1'b0);
    req = 1'b1; cmd_wr = 1'b1; addr = 4'h0; wdata = 8'hFF;
    tick();
    chk_b("scan_valid_s1", scan_valid, 1'b0);
    for (int k = 0; k < 16; k++) begin
      tick();
      chk_b("scan_beat_valid", scan_valid, 1'b1);
      chk_v("scan_beat_addr", {4'h0, scan_addr}, 8'(k));
      chk_v("scan_beat_data", scan_data, 8'(k * 17));
      chk_b("scan_beat_busy", scan_busy, 1'b1);
      chk_b("scan_beat_we", ram_we, 1'b0);
    end
    req = 1'b0; cmd_wr = 1'b0; wdata = '0;
    tick();
    chk_b("scan_end_valid", scan_valid, 1'b0);
    chk_b("scan_end_busy", scan_busy, 1'b0);
    chk_b("scan_end_ready", ready, 1'b1);
`ifdef SCAN_CHECKSUM_EN
    chk_v("scan_sum", scan_sum, 8'hF8);
    tick();
    chk_v("scan_sum_hold", scan_sum, 8'hF8);
`endif
    do_read(4'd0, 8'h00);

    // Collision: read request and scan_start together, read wins
    wait_ready();
    req = 1'b1; cmd_wr = 1'b0; addr = 4'd2; scan_start = 1'b1;
    tick();
    req = 1'b0; scan_start = 1'b0; addr = '0;
    chk_b("coll_scan_busy", scan_busy, 1'b0);
    chk_v("coll_outaddr", {4'h0, ram_outaddr}, 8'h02);
    tick();
    tick();
    chk_b("coll_rvalid", rvalid, 1'b1);
    chk_v("coll_rdata", rdata, 8'h22);
    beats = 0;
    repeat (20) begin
      tick();
      if (scan_valid || scan_busy) beats++;
    end
    chk_v("coll_scan_activity", 8'(beats), 8'h00);

    // Reset in the middle of a scan, at beat 5
    wait_ready();
    scan_start = 1'b1;
    tick();
    scan_start = 1'b0;
    n = 0;
    while (!(scan_valid && scan_addr == 4'd5) && n < 40) begin
      tick();
      n++;
    end
    chk_b("rst_mid_beat5_seen", scan_valid && (scan_addr == 4'd5), 1'b1);
    clrn = 1'b0;
    tick();
    chk_b("rst_mid_scan_valid", scan_valid, 1'b0);
    chk_b("rst_mid_scan_busy", scan_busy, 1'b0);
    chk_b("rst_mid_ready", ready, 1'b1);
    chk_b("rst_mid_we", ram_we, 1'b0);
    clrn = 1'b1;
    do_read(4'd5, 8'h55);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ram_port_ctrl.md
Name: ram_port_ctrl

Overview:
Initiator-side controller for the team's 16x8 synchronous RAM. The RAM has a write port (we/inaddr/indata) and a registered read port (outaddr/outdata); a read happens only in cycles where we=0. This block turns single read/write requests from user logic (switch/key front end) into correctly timed RAM port activity. It also provides an auto-scan mode that streams every RAM word out, in address order, to a display/consumer.

Parameters:
AW, 4, address width; depth = 2**AW
DW, 8, data width

Ports:
clk  input  1  system clock, all logic on rising edge
clrn  input  1  synchronous active-low reset
req  input  1  request strobe, taken when req && ready
cmd_wr  input  1  1 = write, 0 = read; sampled with req
addr  input  AW  request address; sampled with req
wdata  input  DW  write data; sampled with req
ready  output  1  high only in IDLE; request may be accepted
rdata  output  DW  read result; holds last value
rvalid  output  1  one-cycle pulse, rdata valid
wdone  output  1  one-cycle pulse, write committed
scan_start  input  1  start auto-scan; level sampled in IDLE
scan_busy  output  1  high from scan acceptance to last beat
scan_addr  output  AW  address of current scan beat
scan_data  output  DW  data of current scan beat
scan_valid  output  1  scan beat strobe
ram_we  output  1  to RAM we
ram_inaddr  output  AW  to RAM inaddr
ram_indata  output  DW  to RAM indata
ram_outaddr  output  AW  to RAM outaddr
ram_outdata  input  DW  from RAM outdata (registered inside RAM)

Behaviour:
- All outputs are registered. Reset is synchronous: when clrn=0 at an edge, state goes to IDLE and all outputs go to 0, except ready, which goes to 1. ram_we=0 takes effect immediately, so any in-flight write or scan is abandoned. The RAM contents are not touched by reset.
- States: IDLE, WR, RD_ISS, RD_CAP, SCAN, SCAN_DRAIN.
- IDLE: ready=1.
  - req=1 at an edge: latch addr/wdata; ready drops. Next state is WR if cmd_wr=1, else RD_ISS.
  - req=0 and scan_start=1: next state is SCAN with the scan pointer at 0.
  - req and scan_start both high: req wins. scan_start is not remembered.
- WR (one cycle): ram_we=1, ram_inaddr=addr, ram_indata=wdata. The RAM commits at the edge that leaves WR. Next state is IDLE with wdone=1 for one cycle. Next request can be accepted at the edge following wdone.
- RD_ISS: ram_we=0, ram_outaddr=addr. The RAM registers outdata at the exiting edge. Next state is RD_CAP.
- RD_CAP: rdata <= ram_outdata, rvalid=1 for one cycle, next state IDLE.
- Read latency: rvalid is high in the 3rd cycle after the acceptance edge (accept edge E0, RD_ISS E0-E1, RD_CAP E1-E2, rvalid E2-E3).
- Outside WR, ram_we is always 0. ram_inaddr and ram_indata hold their last values.
- SCAN: ram_outaddr = pointer, and the pointer increments every cycle (pipelined). Beat k is presented with scan_valid=1, scan_addr=k, scan_data=RAM[k], exactly 2 cycles after address k was driven. The 2**AW beats are consecutive with no gaps. After pointer 2**AW-1 the state goes to SCAN_DRAIN, which emits the remaining beats and then returns to IDLE. scan_busy is high from the acceptance edge through the last beat. req is ignored (ready=0) during a scan.
- The pointer does not wrap within a scan. Holding scan_start high re-triggers a scan from IDLE.

Optional Feature:
SCAN_CHECKSUM_EN
- Defined: adds output scan_sum [DW-1:0]. It is cleared at scan acceptance and at reset, and accumulates scan_data mod 2**DW on every scan beat. Its final value is stable from the cycle after the last beat until the next scan starts.
- Undefined: the port and logic are absent; all other behaviour is identical.

Test Plan:
- Reset: hold clrn=0 for 2 cycles -> ready=1, ram_we=0, rvalid=wdone=scan_valid=scan_busy=0, rdata=0.
- Write/read: write 0xA5 to addr 3 -> ram_we high for exactly 1 cycle with inaddr=3, wdone pulses. Then read addr 3 -> rvalid 2 edges after acceptance, rdata=0xA5.
- Back-to-back: write 0x3C to addr 15, issue the read of 15 on the first cycle ready=1 returns -> rdata=0x3C. ram_we is never high during RD_ISS.
- Full scan: write addr i = i*0x11 for i=0..15, pulse scan_start -> 16 consecutive scan_valid beats with scan_addr 0..15 and data 0x00..0xFF, scan_busy then drops. With SCAN_CHECKSUM_EN, scan_sum=0xF8.
- Collision: req (read addr 2) and scan_start high in the same IDLE cycle -> read completes, no scan beats occur.
- Reset mid-scan: drive clrn=0 at beat 5 -> at the next edge scan_valid=0, scan_busy=0, ready=1. A following read of addr 5 returns 0x55.
